// File: rtl/bank_core_rsp_queue.sv
// Per-bank core response queue.
// Buffers bank pipeline responses ({pmask, data, tid, tag}) in a circular
// buffer and presents the head entry to the response merge stage. The bank
// pipeline gets no ready; it is throttled early through alm_full, and any
// write that still arrives while the queue is full is dropped and flagged on
// the sticky overflow output.
module bank_core_rsp_queue #(
    parameter int CACHE_ID       = 0,
    parameter int NUM_REQS       = 4,
    parameter int NUM_PORTS      = 1,
    parameter int WORD_SIZE      = 4,
    parameter int CORE_TAG_WIDTH = 8,
    parameter int DEPTH          = 4,
    parameter int ALM_FULL       = DEPTH - 2,
    localparam int REQS_BITS     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int WORD_WIDTH    = 8 * WORD_SIZE
) (
    input  logic                                clk,
    input  logic                                reset,

    // Bank pipeline side
    input  logic                                enq_valid,
    input  logic [NUM_PORTS-1:0]                enq_pmask,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0]     enq_data,
    input  logic [NUM_PORTS*REQS_BITS-1:0]      enq_tid,
    input  logic [NUM_PORTS*CORE_TAG_WIDTH-1:0] enq_tag,
    output logic                                alm_full,
    output logic                                overflow,

    // Response merge side
    output logic                                core_rsp_valid,
    output logic [NUM_PORTS-1:0]                core_rsp_pmask,
    output logic [NUM_PORTS*WORD_WIDTH-1:0]     core_rsp_data,
    output logic [NUM_PORTS*REQS_BITS-1:0]      core_rsp_tid,
    output logic [NUM_PORTS*CORE_TAG_WIDTH-1:0] core_rsp_tag,
    input  logic                                core_rsp_ready
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int DATA_W  = NUM_PORTS * WORD_WIDTH;
    localparam int TID_W   = NUM_PORTS * REQS_BITS;
    localparam int TAG_W   = NUM_PORTS * CORE_TAG_WIDTH;
    localparam int ENTRY_W = NUM_PORTS + DATA_W + TID_W + TAG_W;

    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ALM_FULL_C = CNT_W'(ALM_FULL);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    // Reject parameter sets the pointer arithmetic cannot support: pointers
    // wrap by natural overflow, so DEPTH must be a power of two.
    if (CACHE_ID < 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        ALM_FULL < 1 || ALM_FULL > DEPTH || NUM_PORTS < 1) begin : g_param_check
        $error("bank_core_rsp_queue: illegal parameter set");
    end

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow_q;

    logic               enq_req;
    logic               deq_fire;
    logic               full;
    logic               enq_fire;
    logic               enq_drop;
    logic [ENTRY_W-1:0] enq_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Classify this cycle's enqueue and dequeue events.
    // NOTE: every always_comb output gets a default on entry so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        enq_req  = 1'b0;
        deq_fire = 1'b0;
        full     = 1'b0;
        enq_fire = 1'b0;
        enq_drop = 1'b0;

        // A response with no active port carries nothing and is not an entry.
        enq_req  = !reset && enq_valid && (enq_pmask != '0);
        deq_fire = core_rsp_valid && core_rsp_ready;
        full     = (count == DEPTH_C);
        // When full, a same-cycle dequeue frees the slot being written.
        enq_fire = enq_req && (!full || deq_fire);
        enq_drop = enq_req && full && !deq_fire;
    end

    assign enq_entry  = {enq_pmask, enq_data, enq_tid, enq_tag};
    assign head_entry = mem[rd_ptr];

    // Status outputs are forced low while reset is asserted so the bank and
    // merge stage never see stale state from before the reset.
    assign core_rsp_valid = !reset && (count != '0);
    assign alm_full       = !reset && (count >= ALM_FULL_C);
    assign overflow       = !reset && overflow_q;

    assign {core_rsp_pmask, core_rsp_data, core_rsp_tid, core_rsp_tag} = head_entry;

    // Advance read/write pointers and track occupancy.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (enq_fire && !deq_fire) begin
                count <= count + CNT_ONE;
            end else if (deq_fire && !enq_fire) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Write accepted entries into the storage array.
    // NOTE: the storage array is deliberately not reset; an entry is only
    // observable once count covers it, so its contents after reset are
    // irrelevant and leaving it unreset keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= enq_entry;
        end
    end

    // Latch the sticky overflow flag on any dropped enqueue.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (enq_drop) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bank_core_rsp_queue.sv
// Self-checking bench for bank_core_rsp_queue (DEPTH=4, ALM_FULL=2).
// Stimulus pushes every entry it expects to be accepted into a scoreboard
// queue; an independent monitor pops and compares on each handshake.
module tb_bank_core_rsp_queue;

    localparam int NUM_REQS       = 4;
    localparam int NUM_PORTS      = 1;
    localparam int WORD_SIZE      = 4;
    localparam int CORE_TAG_WIDTH = 8;
    localparam int DEPTH          = 4;
    localparam int ALM_FULL       = 2;
    localparam int REQS_BITS      = 2;
    localparam int WORD_WIDTH     = 32;
    localparam int ENTRY_W        = NUM_PORTS + WORD_WIDTH + REQS_BITS + CORE_TAG_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enq_valid;
    logic [0:0]            enq_pmask;
    logic [31:0]           enq_data;
    logic [1:0]            enq_tid;
    logic [7:0]            enq_tag;
    logic                  alm_full;
    logic                  overflow;
    logic                  core_rsp_valid;
    logic [0:0]            core_rsp_pmask;
    logic [31:0]           core_rsp_data;
    logic [1:0]            core_rsp_tid;
    logic [7:0]            core_rsp_tag;
    logic                  core_rsp_ready;

    logic [ENTRY_W-1:0]    sb [$];
    int                    total  = 0;
    int                    passed = 0;

    bank_core_rsp_queue #(
        .CACHE_ID       (0),
        .NUM_REQS       (NUM_REQS),
        .NUM_PORTS      (NUM_PORTS),
        .WORD_SIZE      (WORD_SIZE),
        .CORE_TAG_WIDTH (CORE_TAG_WIDTH),
        .DEPTH          (DEPTH),
        .ALM_FULL       (ALM_FULL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enq_valid      (enq_valid),
        .enq_pmask      (enq_pmask),
        .enq_data       (enq_data),
        .enq_tid        (enq_tid),
        .enq_tag        (enq_tag),
        .alm_full       (alm_full),
        .overflow       (overflow),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_pmask (core_rsp_pmask),
        .core_rsp_data  (core_rsp_data),
        .core_rsp_tid   (core_rsp_tid),
        .core_rsp_tag   (core_rsp_tag),
        .core_rsp_ready (core_rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [0:0] pm, input logic [31:0] d,
                                                      input logic [1:0] t, input logic [7:0] g);
        return {pm, d, t, g};
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one enqueue for a single edge; record it if it must be kept.
    task automatic enq(input logic [0:0] pm, input logic [31:0] d, input logic [1:0] t,
                       input logic [7:0] g, input bit accept);
        enq_valid = 1'b1;
        enq_pmask = pm;
        enq_data  = d;
        enq_tid   = t;
        enq_tag   = g;
        if (accept) sb.push_back(make_entry(pm, d, t, g));
        tick();
        enq_valid = 1'b0;
        enq_pmask = '0;
    endtask

    // Monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && core_rsp_valid === 1'b1 && core_rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL rsp_unexpected: got 0x%0h expected none at %0t",
                         {core_rsp_pmask, core_rsp_data, core_rsp_tid, core_rsp_tag}, $time);
            end else begin
                logic [ENTRY_W-1:0] exp_e;
                exp_e = sb.pop_front();
                check("rsp_entry", 64'({core_rsp_pmask, core_rsp_data, core_rsp_tid, core_rsp_tag}),
                      64'(exp_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        enq_valid      = 1'b0;
        enq_pmask      = '0;
        enq_data       = '0;
        enq_tid        = '0;
        enq_tag        = '0;
        core_rsp_ready = 1'b0;

        // Reset, with an enqueue attempt that must be ignored.
        tick();
        enq_valid = 1'b1;
        enq_pmask = 1'b1;
        tick();
        check("rst_valid", 64'(core_rsp_valid), 64'd0);
        check("rst_alm_full", 64'(alm_full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        enq_valid = 1'b0;
        enq_pmask = '0;
        reset     = 1'b0;
        tick();
        check("post_rst_valid", 64'(core_rsp_valid), 64'd0);

        // Single entry, one cycle latency, drained next cycle.
        core_rsp_ready = 1'b1;
        enq(1'b1, 32'hDEADBEEF, 2'd2, 8'h5A, 1'b1);
        check("single_valid", 64'(core_rsp_valid), 64'd1);
        check("single_data", 64'(core_rsp_data), 64'hDEADBEEF);
        check("single_tid", 64'(core_rsp_tid), 64'd2);
        check("single_tag", 64'(core_rsp_tag), 64'h5A);
        tick();
        check("single_drained", 64'(core_rsp_valid), 64'd0);

        // Zero pmask is not an entry.
        enq(1'b0, 32'h11111111, 2'd1, 8'h01, 1'b0);
        check("pmask0_valid", 64'(core_rsp_valid), 64'd0);
        check("pmask0_overflow", 64'(overflow), 64'd0);

        // Fill with ready low: alm_full rises after the second write.
        core_rsp_ready = 1'b0;
        enq(1'b1, 32'hB0000001, 2'd0, 8'h10, 1'b1);
        check("fill1_alm_full", 64'(alm_full), 64'd0);
        check("fill1_head", 64'(core_rsp_data), 64'hB0000001);
        enq(1'b1, 32'hB0000002, 2'd1, 8'h11, 1'b1);
        check("fill2_alm_full", 64'(alm_full), 64'd1);
        enq(1'b1, 32'hB0000003, 2'd2, 8'h12, 1'b1);
        enq(1'b1, 32'hB0000004, 2'd3, 8'h13, 1'b1);
        check("fill4_valid", 64'(core_rsp_valid), 64'd1);
        check("fill4_head", 64'(core_rsp_data), 64'hB0000001);
        check("fill4_alm_full", 64'(alm_full), 64'd1);
        check("fill4_overflow", 64'(overflow), 64'd0);

        // Fifth write while full is dropped and flagged.
        enq(1'b1, 32'hB0000005, 2'd0, 8'h14, 1'b0);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_head", 64'(core_rsp_data), 64'hB0000001);
        core_rsp_ready = 1'b1;
        repeat (4) tick();
        check("ovf_drained", 64'(core_rsp_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        core_rsp_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Full with simultaneous enqueue and dequeue.
        enq(1'b1, 32'hC0000001, 2'd0, 8'h20, 1'b1);
        enq(1'b1, 32'hC0000002, 2'd1, 8'h21, 1'b1);
        enq(1'b1, 32'hC0000003, 2'd2, 8'h22, 1'b1);
        enq(1'b1, 32'hC0000004, 2'd3, 8'h23, 1'b1);
        core_rsp_ready = 1'b1;
        enq(1'b1, 32'hC0000005, 2'd0, 8'h24, 1'b1);
        check("fullsim_valid", 64'(core_rsp_valid), 64'd1);
        check("fullsim_alm_full", 64'(alm_full), 64'd1);
        check("fullsim_overflow", 64'(overflow), 64'd0);
        check("fullsim_head", 64'(core_rsp_data), 64'hC0000002);
        repeat (4) tick();
        check("fullsim_drained", 64'(core_rsp_valid), 64'd0);

        // Back-to-back streaming across several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            enq(1'b1, 32'hE0000000 + 32'(i), 2'(i), 8'h30 + 8'(i), 1'b1);
            check("wrap_alm_full", 64'(alm_full), 64'd0);
        end
        tick();
        check("wrap_drained", 64'(core_rsp_valid), 64'd0);
        check("wrap_overflow", 64'(overflow), 64'd0);

        // Reset in the middle of operation discards contents.
        core_rsp_ready = 1'b0;
        enq(1'b1, 32'hF0000001, 2'd1, 8'h40, 1'b1);
        enq(1'b1, 32'hF0000002, 2'd2, 8'h41, 1'b1);
        enq(1'b1, 32'hF0000003, 2'd3, 8'h42, 1'b1);
        check("mid_alm_full", 64'(alm_full), 64'd1);
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_valid", 64'(core_rsp_valid), 64'd0);
        check("mid_rst_alm_full", 64'(alm_full), 64'd0);
        tick();
        reset = 1'b0;
        check("mid_post_valid", 64'(core_rsp_valid), 64'd0);
        check("mid_post_alm_full", 64'(alm_full), 64'd0);
        check("mid_post_overflow", 64'(overflow), 64'd0);
        core_rsp_ready = 1'b1;
        enq(1'b1, 32'h0D0D0D0D, 2'd3, 8'hA5, 1'b1);
        check("mid_next_valid", 64'(core_rsp_valid), 64'd1);
        check("mid_next_data", 64'(core_rsp_data), 64'h0D0D0D0D);
        tick();
        check("mid_next_drained", 64'(core_rsp_valid), 64'd0);

        // Every expected entry must have been delivered.
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
